// File: rtl/icache_fetch_responder.sv
// Direct-mapped, read-only instruction cache with word-serial line refill.
// Optional ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_fetch_responder #(
    parameter int          LINES          = 16,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] NOP_WORD       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction_address,
    output logic [31:0] instruction_read_data,
    output logic        instruction_valid,
    input  logic        icache_flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = 30 - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t           state;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [OFF_W-1:0] word_cnt;
    logic             pend_flush;

    logic [OFF_W-1:0] addr_off;
    logic [IDX_W-1:0] addr_idx;
    logic [TAG_W-1:0] addr_tag;
    logic             lookup_hit;
    logic             hit;
    logic             word_we;
    logic             refill_last;
    logic             unused_addr_bits;

    assign addr_off         = instruction_address[OFF_W+1:2];
    assign addr_idx         = instruction_address[IDX_W+OFF_W+1:OFF_W+2];
    assign addr_tag         = instruction_address[31:IDX_W+OFF_W+2];
    assign unused_addr_bits = &instruction_address[1:0];

    assign lookup_hit  = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    // A flush cycle never reports a hit, even for a line that is valid going in.
    assign hit         = (state == IDLE) && lookup_hit && !icache_flush;
    assign word_we     = (state == REFILL) && mem_ack;
    assign refill_last = word_we && (word_cnt == LAST_WORD);

    always_comb begin
        instruction_valid     = hit;
        instruction_read_data = NOP_WORD;
        if (hit) instruction_read_data = data_q[addr_idx][addr_off];
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid_q    <= '0;
            fill_idx   <= '0;
            fill_tag   <= '0;
            word_cnt   <= '0;
            pend_flush <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (icache_flush) valid_q <= '0;
                    if (!lookup_hit) begin
                        state              <= REFILL;
                        fill_idx           <= addr_idx;
                        fill_tag           <= addr_tag;
                        valid_q[addr_idx]  <= 1'b0;
                        word_cnt           <= '0;
                        pend_flush         <= 1'b0;
                        mem_req            <= 1'b1;
                        mem_addr           <= {addr_tag, addr_idx, {OFF_W{1'b0}}, 2'b00};
                    end
                end
                REFILL: begin
                    if (icache_flush) pend_flush <= 1'b1;
                    if (mem_ack) begin
                        if (word_cnt != LAST_WORD) begin
                            word_cnt <= word_cnt + 1'b1;
                            mem_addr <= mem_addr + 32'd4;
                        end else begin
                            state      <= IDLE;
                            mem_req    <= 1'b0;
                            pend_flush <= 1'b0;
                            // A flush seen at any point of the refill wins over the new line.
                            if (pend_flush || icache_flush) valid_q <= '0;
                            else                            valid_q[fill_idx] <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: data and tag arrays are not reset; valid_q alone gates their use.
    always_ff @(posedge clk) begin
        if (word_we)     data_q[fill_idx][word_cnt] <= mem_rdata;
        if (refill_last) tag_q[fill_idx]            <= fill_tag;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != 32'hFFFF_FFFF))
                hit_count <= hit_count + 32'd1;
            if ((state == IDLE) && !lookup_hit && (miss_count != 32'hFFFF_FFFF))
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed self-checking bench for icache_fetch_responder (LINES=16, WORDS_PER_LINE=4).
module tb_icache_fetch_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction_address;
    logic [31:0] instruction_read_data;
    logic        instruction_valid;
    logic        icache_flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    icache_fetch_responder dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .instruction_address   (instruction_address),
        .instruction_read_data (instruction_read_data),
        .instruction_valid     (instruction_valid),
        .icache_flush          (icache_flush),
        .mem_req               (mem_req),
        .mem_addr              (mem_addr),
        .mem_ack               (mem_ack),
        .mem_rdata             (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count             (hit_count),
        .miss_count            (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lookup(input string name, input logic exp_valid, input logic [31:0] exp_data);
        checks++;
        if (instruction_valid !== exp_valid || instruction_read_data !== exp_data) begin
            failures++;
            $display("FAIL %s: valid=%b data=%h, expected valid=%b data=%h",
                     name, instruction_valid, instruction_read_data, exp_valid, exp_data);
        end
    endtask

    task automatic expect_req(input string name, input logic exp_req, input logic [31:0] exp_addr);
        checks++;
        if (mem_req !== exp_req || (exp_req && mem_addr !== exp_addr)) begin
            failures++;
            $display("FAIL %s: mem_req=%b mem_addr=%h, expected mem_req=%b mem_addr=%h",
                     name, mem_req, mem_addr, exp_req, exp_addr);
        end
    endtask

    // One refill word: verify request/address, one wait cycle, then a one-cycle ack.
    task automatic serve_word(input logic [31:0] exp_addr, input logic [31:0] word);
        expect_req("refill_req", 1'b1, exp_addr);
        tick();
        expect_lookup("refill_no_valid", 1'b0, NOP);
        mem_ack   = 1'b1;
        mem_rdata = word;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic serve_line(input logic [31:0] base, input logic [31:0] word0);
        for (int i = 0; i < 4; i++) serve_word(base + 32'(4 * i), word0 + 32'(i));
        expect_req("refill_done_req_low", 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instruction_address = 32'h0;
        icache_flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        repeat (2) tick();
        expect_lookup("reset_lookup", 1'b0, NOP);
        expect_req("reset_req", 1'b0, 32'h0);
        rst_n = 1'b1;
        tick();
        expect_req("reset_refill_start", 1'b1, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        expect_req("reset_async_abort", 1'b0, 32'h0);
        expect_lookup("reset_async_lookup", 1'b0, NOP);
        tick();
        rst_n = 1'b1;
        expect_lookup("reset_release_miss", 1'b0, NOP);
        tick();
        serve_line(32'h0, 32'h50);
        expect_lookup("reset_line0_hit", 1'b1, 32'h50);
    endtask

    task automatic test_cold_miss();
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        mem_rdata = '0;
        expect_lookup("stray_ack_ignored", 1'b1, 32'h50);
        expect_req("stray_ack_no_req", 1'b0, 32'h0);
        instruction_address = 32'h100;
        #1 expect_lookup("cold_miss_lookup", 1'b0, NOP);
        tick();
        serve_line(32'h100, 32'hA0);
        expect_lookup("cold_first_hit", 1'b1, 32'hA0);
        instruction_address = 32'h10C;
        #1 expect_lookup("cold_last_word", 1'b1, 32'hA3);
    endtask

    task automatic test_conflict();
        instruction_address = 32'h200;
        #1 expect_lookup("conflict_miss", 1'b0, NOP);
        tick();
        serve_line(32'h200, 32'hB0);
        expect_lookup("conflict_hit", 1'b1, 32'hB0);
        instruction_address = 32'h100;
        #1 expect_lookup("conflict_evicted", 1'b0, NOP);
        tick();
        serve_line(32'h100, 32'hA0);
        expect_lookup("conflict_refilled", 1'b1, 32'hA0);
    endtask

    task automatic test_addr_switch();
        icache_flush = 1'b1;
        #1 expect_lookup("switch_flush_cycle", 1'b0, NOP);
        tick();
        icache_flush = 1'b0;
        expect_lookup("switch_after_flush", 1'b0, NOP);
        expect_req("switch_idle_no_req", 1'b0, 32'h0);
        tick();
        serve_word(32'h100, 32'hC0);
        instruction_address = 32'h040;
        #1 expect_lookup("switch_during_refill", 1'b0, NOP);
        serve_word(32'h104, 32'hC1);
        serve_word(32'h108, 32'hC2);
        serve_word(32'h10C, 32'hC3);
        expect_lookup("switch_new_addr_miss", 1'b0, NOP);
        expect_req("switch_idle_gap", 1'b0, 32'h0);
        tick();
        serve_line(32'h040, 32'hD0);
        expect_lookup("switch_040_hit", 1'b1, 32'hD0);
        instruction_address = 32'h100;
        #1 expect_lookup("switch_100_hit", 1'b1, 32'hC0);
        tick();
        expect_req("switch_100_no_traffic", 1'b0, 32'h0);
    endtask

    task automatic test_flush();
        instruction_address = 32'h104;
        #1 expect_lookup("flush_pre_hit", 1'b1, 32'hC1);
        icache_flush = 1'b1;
        #1 expect_lookup("flush_cycle_forced", 1'b0, NOP);
        tick();
        icache_flush = 1'b0;
        expect_lookup("flush_104_miss", 1'b0, NOP);
        tick();
        serve_line(32'h100, 32'hE0);
        expect_lookup("flush_104_refilled", 1'b1, 32'hE1);
        instruction_address = 32'h300;
        #1 expect_lookup("flush_300_miss", 1'b0, NOP);
        tick();
        serve_word(32'h300, 32'hF0);
        icache_flush = 1'b1;
        tick();
        icache_flush = 1'b0;
        serve_word(32'h304, 32'hF1);
        serve_word(32'h308, 32'hF2);
        serve_word(32'h30C, 32'hF3);
        expect_req("flush_refill_done", 1'b0, 32'h0);
        expect_lookup("flush_pending_applied", 1'b0, NOP);
        tick();
        serve_line(32'h300, 32'hF0);
        expect_lookup("flush_300_hit", 1'b1, 32'hF0);
    endtask

    task automatic test_flush_and_miss();
        instruction_address = 32'h510;
        icache_flush = 1'b1;
        #1 expect_lookup("flush_miss_lookup", 1'b0, NOP);
        tick();
        icache_flush = 1'b0;
        serve_line(32'h510, 32'h70);
        expect_lookup("flush_miss_hit", 1'b1, 32'h70);
        instruction_address = 32'h300;
        #1 expect_lookup("flush_miss_300_cleared", 1'b0, NOP);
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        instruction_address = 32'h600;
        tick();
        rst_n = 1'b1;
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            failures++;
            $display("FAIL stats_reset: hit=%0d miss=%0d, expected 0 0", hit_count, miss_count);
        end
        tick();
        serve_line(32'h600, 32'h90);
        repeat (3) tick();
        checks++;
        if (hit_count !== 32'd3 || miss_count !== 32'd1) begin
            failures++;
            $display("FAIL stats_counts: hit=%0d miss=%0d, expected 3 1", hit_count, miss_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_addr_switch();
        test_flush();
        test_flush_and_miss();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
